uart_bus_master: RTL

Host-side initiator for the UART controller's register bus. Converts single-cycle valid/ready register requests into timed chip-select/read-write/tristate-data bus cycles on chip_sel_n, read_write, address and data.
- Guarantees the CS de-assertion gap the UART's posedge detectors need between accesses.
- Synchronises the UART's active-low interrupt request.
- Optionally services the interrupt autonomously.

---
 rtl/uart_pkg.sv | 15 +
 rtl/ireq_synchronizer.sv | 20 ++
 rtl/uart_bus_master.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART host-side register bus master.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    ACCESS   = 3'd2,
    RECOVER  = 3'd3,
    VEC_READ = 3'd4,
    IACK     = 3'd5
  } bus_master_state_e;

  localparam logic [2:0] INT_VECTOR_ADDR = 3'd5;

endpackage

// File: rtl/ireq_synchronizer.sv
// Two-flop synchroniser for the UART's asynchronous active-low interrupt
// request. Resets to 1 so no interrupt is seen while coming out of reset.
module ireq_synchronizer (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] ff_q;

  // shift the asynchronous level through two flops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ff_q <= 2'b11;
    else          ff_q <= {ff_q[0], async_i};
  end

  assign sync_o = ff_q[1];

endmodule

// File: rtl/uart_bus_master.sv
// Host-side initiator for the UART register bus: turns valid/ready requests
// into SETUP / ACCESS (CS low) / RECOVER bus cycles with a guaranteed CS-high
// gap between accesses, and synchronises the UART interrupt request.
// Build option: UART_MST_AUTO_IACK_EN -- the block fetches the interrupt
// vector itself and pulses iack_o; otherwise iack_o is irq_ack_i delayed by
// one cycle and the vector outputs stay 0.
//
// state    | meaning
// IDLE     | ready for a host request, read_write_o parked at 1
// SETUP    | address/direction driven, CS high, one cycle
// ACCESS   | CS low for ACCESS_CYCLES cycles
// RECOVER  | CS high for IDLE_CYCLES cycles
// VEC_READ | setup cycle of an internal interrupt-vector read
// IACK     | iack_o high for IACK_CYCLES cycles
module uart_bus_master
  import uart_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 4,
  parameter int unsigned READ_SAMPLE   = 3,
  parameter int unsigned IDLE_CYCLES   = 2,
  parameter int unsigned IACK_CYCLES   = 2,
  parameter logic [2:0]  INT_VEC_ADDR  = INT_VECTOR_ADDR
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_write_i,
  input  logic [2:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       chip_sel_n_o,
  output logic [2:0] address_o,
  output logic       read_write_o,
  inout  wire  [7:0] data_io,
  input  logic       ireq_n_i,
  output logic       iack_o,
  output logic       irq_pending_o,
  input  logic       irq_ack_i,
  output logic       irq_vec_valid_o,
  output logic [7:0] irq_vec_o
);

  if (ACCESS_CYCLES < 2 || ACCESS_CYCLES > 256) begin : g_bad_access
    $error("ACCESS_CYCLES must be in 2..256");
  end
  if (READ_SAMPLE < 1 || READ_SAMPLE > ACCESS_CYCLES) begin : g_bad_sample
    $error("READ_SAMPLE must be in 1..ACCESS_CYCLES");
  end
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 256) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 1..256");
  end
  if (IACK_CYCLES < 1 || IACK_CYCLES > 256) begin : g_bad_iack
    $error("IACK_CYCLES must be in 1..256");
  end

  localparam logic [7:0] ACC_LAST  = 8'(ACCESS_CYCLES - 1);
  localparam logic [7:0] IDL_LAST  = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] IACK_LAST = 8'(IACK_CYCLES - 1);
  localparam logic [7:0] SMP_IDX   = 8'(READ_SAMPLE - 1);

  bus_master_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_max;
  logic       write_q, vec_q, rsp_valid_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q, rdata_q;
  logic       ireq_sync, irq_take_w, data_oe;
  logic       accept_w, vec_start_w, fetch_done_w, sample_w;

  ireq_synchronizer u_ireq_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (ireq_n_i),
    .sync_o  (ireq_sync)
  );

  assign irq_pending_o = ~ireq_sync;

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next-state: fixed-length phases timed by the shared counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (irq_take_w)       state_d = VEC_READ;
        else if (req_valid_i) state_d = SETUP;
      end
      SETUP, VEC_READ: state_d = ACCESS;
      ACCESS:  if (cnt_q == ACC_LAST) state_d = RECOVER;
      RECOVER: if (cnt_q == IDL_LAST) state_d = vec_q ? IACK : IDLE;
      IACK:    if (cnt_q == IACK_LAST) state_d = RECOVER;
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from the registered state, so CS cannot glitch
  always_comb begin
    chip_sel_n_o = 1'b1;
    read_write_o = 1'b1;
    req_ready_o  = 1'b0;
    data_oe      = 1'b0;
    case (state_q)
      IDLE:    req_ready_o = ~irq_take_w;
      SETUP:   begin read_write_o = ~write_q; data_oe = write_q; end
      VEC_READ: read_write_o = 1'b1;
      ACCESS:  begin chip_sel_n_o = 1'b0; read_write_o = ~write_q; data_oe = write_q; end
      RECOVER: begin read_write_o = ~write_q; data_oe = write_q & (cnt_q == 8'd0); end
      default: read_write_o = 1'b1;
    endcase
  end

  assign accept_w     = (state_q == IDLE) && (state_d == SETUP);
  assign vec_start_w  = (state_q == IDLE) && (state_d == VEC_READ);
  assign fetch_done_w = (state_q == ACCESS) && (state_d == RECOVER);
  assign sample_w     = (state_q == ACCESS) && (cnt_q == SMP_IDX) && !write_q;

  assign address_o   = addr_q;
  assign data_io     = data_oe ? wdata_q : 8'bz;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;

  // phase length limit for the saturating counter
  always_comb begin
    cnt_max = 8'd0;
    case (state_q)
      ACCESS:  cnt_max = ACC_LAST;
      RECOVER: cnt_max = IDL_LAST;
      IACK:    cnt_max = IACK_LAST;
      default: cnt_max = 8'd0;
    endcase
  end

  // phase counter: cleared on every state change, saturates at the phase end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)               cnt_q <= 8'd0;
    else if (state_d != state_q) cnt_q <= 8'd0;
    else if (cnt_q != cnt_max)  cnt_q <= cnt_q + 8'd1;
  end

  // request capture, read sampling and completion pulse
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      write_q     <= 1'b0;
      addr_q      <= 3'd0;
      wdata_q     <= 8'd0;
      vec_q       <= 1'b0;
      rdata_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (accept_w) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end else if (vec_start_w) begin
        write_q <= 1'b0;
        addr_q  <= INT_VEC_ADDR;
      end
      if (vec_start_w)                                    vec_q <= 1'b1;
      else if ((state_q == RECOVER) && (state_d == IACK)) vec_q <= 1'b0;
      if (sample_w && !vec_q) rdata_q <= data_io;
      rsp_valid_q <= fetch_done_w & ~vec_q;
    end
  end

`ifdef UART_MST_AUTO_IACK_EN
  logic       armed_q, vec_valid_q;
  logic [7:0] irq_vec_q;
  logic       unused_irq_ack;

  // arm once per interrupt: disarm at fetch, re-arm when the request drops
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      armed_q     <= 1'b1;
      vec_valid_q <= 1'b0;
      irq_vec_q   <= 8'd0;
    end else begin
      if (fetch_done_w && vec_q) armed_q <= 1'b0;
      else if (!irq_pending_o)   armed_q <= 1'b1;
      if (sample_w && vec_q) irq_vec_q <= data_io;
      vec_valid_q <= fetch_done_w & vec_q;
    end
  end

  assign irq_take_w      = armed_q & irq_pending_o;
  assign iack_o          = (state_q == IACK);
  assign irq_vec_o       = irq_vec_q;
  assign irq_vec_valid_o = vec_valid_q;
  assign unused_irq_ack  = irq_ack_i;
`else
  logic iack_q;

  // manual mode: host acknowledge forwarded one cycle later
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) iack_q <= 1'b0;
    else          iack_q <= irq_ack_i;
  end

  assign irq_take_w      = 1'b0;
  assign iack_o          = iack_q;
  assign irq_vec_o       = 8'd0;
  assign irq_vec_valid_o = 1'b0;
`endif

endmodule
